// File: rtl/rare_clk_switch_ctrl.sv
// rare_clk_switch_ctrl: glitch-safe main clock source switch and divided-DCO frequency measurement sequencer
// Ports: clk, rst (sync, active-high); switch: sw_start, sel_req -> clk_select, clk_gate_en, sw_busy, sw_done;
// measure: meas_start, meas_window, meas_edge -> freq_out_cnt_clk_select, meas_busy, meas_valid, meas_count.
// Optional RARE_MEAS_OVF_EN adds meas_ovf: edges were lost to counter saturation in the last window.
module rare_clk_switch_ctrl #(
  parameter int SETTLE_CYCLES = 16,
  parameter int WIN_WIDTH = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sw_start,
  input  logic                 sel_req,
  output logic                 clk_select,
  output logic                 clk_gate_en,
  output logic                 sw_busy,
  output logic                 sw_done,
  input  logic                 meas_start,
  input  logic [WIN_WIDTH-1:0] meas_window,
  input  logic                 meas_edge,
  output logic                 freq_out_cnt_clk_select,
  output logic                 meas_busy,
  output logic                 meas_valid,
  output logic [CNT_WIDTH-1:0] meas_count
`ifdef RARE_MEAS_OVF_EN
  ,
  output logic                 meas_ovf
`endif
);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  typedef enum logic [1:0] {S_IDLE, S_GATE, S_SWAP, S_UNGATE} s_t;
  typedef enum logic [1:0] {M_IDLE, M_SETUP, M_COUNT, M_DONE} m_t;
  s_t s_state, s_next;
  m_t m_state, m_next;
  logic [SW-1:0] s_cnt, m_cnt;
  logic [WIN_WIDTH-1:0] rem;
  logic [CNT_WIDTH-1:0] cnt;
  logic sel_q, prev, ovf_q, sw_go, meas_go, s_last, m_last, rise;
  // switch wins a same-cycle tie; neither sequence may start while the other runs
  assign sw_go = s_state == S_IDLE && m_state == M_IDLE && sw_start;
  assign meas_go = s_state == S_IDLE && m_state == M_IDLE && meas_start && !sw_start;
  assign s_last = s_cnt == SW'(SETTLE_CYCLES - 1);
  assign m_last = m_cnt == SW'(SETTLE_CYCLES - 1);
  assign rise = meas_edge & ~prev;
  always_ff @(posedge clk) begin
    if (rst) begin
      s_state <= S_IDLE;
      m_state <= M_IDLE;
      s_cnt <= '0;
      m_cnt <= '0;
      rem <= '0;
      cnt <= '0;
      sel_q <= 1'b0;
      prev <= 1'b0;
      ovf_q <= 1'b0;
      clk_select <= 1'b0;
      sw_done <= 1'b0;
      meas_valid <= 1'b0;
      meas_count <= '0;
`ifdef RARE_MEAS_OVF_EN
      meas_ovf <= 1'b0;
`endif
    end else begin
      s_state <= s_next;
      m_state <= m_next;
      s_cnt <= s_next != s_state ? '0 : s_cnt + SW'(1);
      m_cnt <= m_next != m_state ? '0 : m_cnt + SW'(1);
      prev <= meas_edge;
      if (sw_go) sel_q <= sel_req;
      // select changes only on entry to S_SWAP, with the gate already closed
      if (s_state == S_GATE && s_last) clk_select <= sel_q;
      sw_done <= (sw_go && sel_req == clk_select) || s_state == S_UNGATE;
      if (meas_go) rem <= meas_window;
      else if (m_state == M_COUNT) rem <= rem - WIN_WIDTH'(1);
      if (m_state == M_SETUP) begin
        cnt <= '0;
        ovf_q <= 1'b0;
      end else if (m_state == M_COUNT) begin
        cnt <= cnt + CNT_WIDTH'(rise && !(&cnt));
        ovf_q <= ovf_q | (rise & (&cnt));
      end
      meas_valid <= m_state == M_DONE;
      if (m_state == M_DONE) meas_count <= cnt;
`ifdef RARE_MEAS_OVF_EN
      if (m_state == M_DONE) meas_ovf <= ovf_q;
`endif
    end
  end
  always_comb begin
    s_next = s_state;
    m_next = m_state;
    unique case (s_state)
      S_IDLE:  s_next = (sw_go && sel_req != clk_select) ? S_GATE : S_IDLE;
      S_GATE:  s_next = s_last ? S_SWAP : S_GATE;
      S_SWAP:  s_next = s_last ? S_UNGATE : S_SWAP;
      default: s_next = S_IDLE;
    endcase
    unique case (m_state)
      M_IDLE:  m_next = meas_go ? M_SETUP : M_IDLE;
      M_SETUP: m_next = m_last ? (rem == '0 ? M_DONE : M_COUNT) : M_SETUP;
      M_COUNT: m_next = rem == WIN_WIDTH'(1) ? M_DONE : M_COUNT;
      default: m_next = M_IDLE;
    endcase
  end
  always_comb begin
    clk_gate_en = !(s_state == S_GATE || s_state == S_SWAP);
    sw_busy = s_state != S_IDLE;
    freq_out_cnt_clk_select = m_state == M_SETUP || m_state == M_COUNT;
    meas_busy = m_state != M_IDLE;
  end
endmodule

// File: tb/tb_rare_clk_switch_ctrl.sv
// tb_rare_clk_switch_ctrl: scoreboard bench for rare_clk_switch_ctrl (SETTLE_CYCLES=4, plus a CNT_WIDTH=4 instance)
module tb_rare_clk_switch_ctrl;
  localparam int S = 4;
  typedef struct {int val; int at;} exp_t;
  logic clk = 0, rst = 1;
  logic sw_start = 0, sel_req = 0, meas_start = 0, meas_start1 = 0, meas_edge = 0, tog_en = 0;
  logic [15:0] meas_window = 0;
  logic clk_select, clk_gate_en, sw_busy, sw_done, freq_sel, meas_busy, meas_valid;
  logic [15:0] meas_count;
  logic sel1, gate1, swb1, swd1, fsel1, mb1, mv1;
  logic [3:0] meas_count1;
`ifdef RARE_MEAS_OVF_EN
  logic ovf0, ovf1;
`endif
  exp_t q_sw[$], q_m[$], q_m1[$];
  exp_t e;
  int cyc = 0, tc = 0, n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (tog_en) begin
    tc++;
    if (tc % 5 == 0) meas_edge = ~meas_edge;
  end
  rare_clk_switch_ctrl #(.SETTLE_CYCLES(S), .WIN_WIDTH(16), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .sw_start(sw_start), .sel_req(sel_req), .clk_select(clk_select),
    .clk_gate_en(clk_gate_en), .sw_busy(sw_busy), .sw_done(sw_done), .meas_start(meas_start),
    .meas_window(meas_window), .meas_edge(meas_edge), .freq_out_cnt_clk_select(freq_sel),
    .meas_busy(meas_busy), .meas_valid(meas_valid), .meas_count(meas_count)
`ifdef RARE_MEAS_OVF_EN
    , .meas_ovf(ovf0)
`endif
  );
  rare_clk_switch_ctrl #(.SETTLE_CYCLES(S), .WIN_WIDTH(16), .CNT_WIDTH(4)) dut1 (
    .clk(clk), .rst(rst), .sw_start(1'b0), .sel_req(1'b0), .clk_select(sel1),
    .clk_gate_en(gate1), .sw_busy(swb1), .sw_done(swd1), .meas_start(meas_start1),
    .meas_window(meas_window), .meas_edge(meas_edge), .freq_out_cnt_clk_select(fsel1),
    .meas_busy(mb1), .meas_valid(mv1), .meas_count(meas_count1)
`ifdef RARE_MEAS_OVF_EN
    , .meas_ovf(ovf1)
`endif
  );
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (sw_done) begin
      if (q_sw.size() == 0) chk("sw_done_unexpected", 1, 0);
      else begin
        e = q_sw.pop_front();
        chk("sw_done_sel", int'(clk_select), e.val);
        chk("sw_done_cycle", cyc, e.at);
      end
    end
    if (meas_valid) begin
      if (q_m.size() == 0) chk("meas_valid_unexpected", 1, 0);
      else begin
        e = q_m.pop_front();
        chk("meas_count", int'(meas_count), e.val);
        chk("meas_valid_cycle", cyc, e.at);
      end
    end
    if (mv1) begin
      if (q_m1.size() == 0) chk("meas_valid1_unexpected", 1, 0);
      else begin
        e = q_m1.pop_front();
        chk("sat_count", int'(meas_count1), e.val);
        chk("sat_valid_cycle", cyc, e.at);
`ifdef RARE_MEAS_OVF_EN
        chk("sat_ovf", int'(ovf1), 1);
        chk("nosat_ovf", int'(ovf0), 0);
`endif
      end
    end
    if (swd1) chk("dut1_sw_done_unexpected", 1, 0);
  end
  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic sw(input logic s, input int lat);
    @(negedge clk);
    sw_start = 1;
    sel_req = s;
    if (lat > 0) q_sw.push_back('{int'(s), cyc + lat});
    @(negedge clk);
    sw_start = 0;
  endtask
  task automatic meas(input int w, input int expc, input bit push);
    @(negedge clk);
    meas_start = 1;
    meas_window = 16'(w);
    if (push) q_m.push_back('{expc, cyc + w + S + 2});
    @(negedge clk);
    meas_start = 0;
  endtask
  initial begin
    int gl, sk, fh;
    tog_en = 1;
    wait_n(3);
    chk("rst_clk_select", int'(clk_select), 0);
    chk("rst_gate_en", int'(clk_gate_en), 1);
    chk("rst_freq_sel", int'(freq_sel), 0);
    chk("rst_meas_count", int'(meas_count), 0);
    chk("rst_busy_pulses", int'({sw_busy, sw_done, meas_busy, meas_valid}), 0);
    rst = 0;
    // equal select: done next cycle, no gating
    sw(0, 1);
    gl = 0;
    for (int k = 1; k <= 4; k++) begin
      if (!clk_gate_en) gl++;
      if (k < 4) @(negedge clk);
    end
    chk("equal_gate_low_cycles", gl, 0);
    // full switch DCO -> FPGA
    sw(1, 2 * S + 2);
    gl = 0;
    sk = 0;
    for (int k = 1; k <= 11; k++) begin
      if (!clk_gate_en) gl++;
      if (clk_select && sk == 0) sk = k;
      if (k == 1) chk("sw_busy_after_start", int'(sw_busy), 1);
      if (k < 11) @(negedge clk);
    end
    chk("gate_low_cycles", gl, 2 * S);
    chk("sel_change_cycle", sk, S + 1);
    chk("sw_busy_after_done", int'(sw_busy), 0);
    // measurement, window 100, period-10 edge -> 10 rises
    meas(100, 10, 1);
    fh = 0;
    for (int k = 1; k <= 106; k++) begin
      if (freq_sel) fh++;
      if (k < 106) @(negedge clk);
    end
    chk("freq_sel_cycles", fh, S + 100);
    chk("freq_sel_after", int'(freq_sel), 0);
    // zero window skips counting
    meas(0, 0, 1);
    wait_n(10);
    // simultaneous starts: switch wins
    @(negedge clk);
    sw_start = 1;
    sel_req = 0;
    meas_start = 1;
    meas_window = 16'd50;
    q_sw.push_back('{0, cyc + 2 * S + 2});
    @(negedge clk);
    sw_start = 0;
    meas_start = 0;
    wait_n(3);
    meas(30, 0, 0);
    wait_n(15);
    // switch request during measurement is ignored
    meas(50, 5, 1);
    wait_n(10);
    sw(1, 0);
    wait_n(60);
    chk("sel_held_after_ignored_sw", int'(clk_select), 0);
    // reset in the middle of S_SWAP
    sw(1, 0);
    wait_n(S + 1);
    chk("pre_rst_sel", int'(clk_select), 1);
    chk("pre_rst_gate", int'(clk_gate_en), 0);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("mid_rst_sel", int'(clk_select), 0);
    chk("mid_rst_gate", int'(clk_gate_en), 1);
    chk("mid_rst_busy", int'(sw_busy), 0);
    wait_n(15);
    // 4-bit counter saturation: 20 rises in window 200
    @(negedge clk);
    meas_start1 = 1;
    meas_window = 16'd200;
    q_m1.push_back('{15, cyc + 200 + S + 2});
    @(negedge clk);
    meas_start1 = 0;
    for (int i = 0; i < 400 && (q_sw.size() + q_m.size() + q_m1.size()) > 0; i++) @(negedge clk);
    chk("scoreboard_drained", q_sw.size() + q_m.size() + q_m1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
